// File: rtl/aes_pkg.sv
// Shared AES helpers for the round datapath.
// Contents:
//   AES_POLY - low byte of the field modulus 0x11B
//   xtime    - multiply a field element by 2
//   gf_mul   - multiply by one of the MixColumns constants 1/2/3/9/b/d/e
//   state_t  - sequencing states of the column-serial MixColumns block
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Higher multiples come from an xtime chain: x*8 = xtime(xtime(xtime(x))).
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      4'h2:    return x2;
      4'h3:    return x2 ^ x;
      4'h9:    return x8 ^ x;
      4'hb:    return x8 ^ x2 ^ x;
      4'hd:    return x8 ^ x4 ^ x;
      4'he:    return x8 ^ x4 ^ x2;
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational (Inv)MixColumns on one 32-bit column.
// Ports:
//   col_in  [0:31] - input column, row r = bits 8r..8r+7 (bit 8r is MSB)
//   col_out [0:31] - mixed column, same byte ordering
// INVERSE = 0 uses coefficients 02 03 01 01, INVERSE = 1 uses 0e 0b 0d 09.
module mix_single_column
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [0:31] col_in,
  output logic [0:31] col_out
);

  localparam logic [3:0] C0 = INVERSE ? 4'he : 4'h2;
  localparam logic [3:0] C1 = INVERSE ? 4'hb : 4'h3;
  localparam logic [3:0] C2 = INVERSE ? 4'hd : 4'h1;
  localparam logic [3:0] C3 = INVERSE ? 4'h9 : 4'h1;

  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      col_out[8*r +: 8] = gf_mul(col_in[8*r +: 8], C0)
                        ^ gf_mul(col_in[8*((r+1)%4) +: 8], C1)
                        ^ gf_mul(col_in[8*((r+2)%4) +: 8], C2)
                        ^ gf_mul(col_in[8*((r+3)%4) +: 8], C3);
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns stage, one column per clock.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - upstream handshake for data_in + last_round
//   data_in [0:127]       - AES state, column c = bytes 4c..4c+3
//   last_round            - 1 = pass the block through unmixed
//   out_valid/out_ready   - downstream handshake for data_out
//   data_out [0:127]      - finished block, held stable until taken
//   busy                  - block owns a state (COMPUTE or DONE)
//
// state   | meaning
// IDLE    | waiting for a block, in_ready high
// COMPUTE | rewriting column col of the work register, one per edge
// DONE    | result on data_out; handshake may also accept the next block
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:127]  data_in,
  input  logic          last_round,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:127]  data_out,
  output logic          busy
);

  state_t       state, state_nx;
  logic [0:127] work;
  logic         bypass;
  logic [1:0]   col;
  logic [0:31]  col_cur, col_mix;
  logic         accept;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign data_out  = work;

  // col * 32 as a bit offset into the work register.
  assign col_cur = work[{col, 5'b00000} +: 32];

  mix_single_column #(.INVERSE(INVERSE)) u_mix (
    .col_in  (col_cur),
    .col_out (col_mix)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = COMPUTE;
      COMPUTE: if (col == 2'd3) state_nx = DONE;
      DONE:    if (out_ready) state_nx = in_valid ? COMPUTE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      bypass <= 1'b0;
      col    <= 2'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        work   <= data_in;
        bypass <= last_round;
        col    <= 2'd0;
      end else if (state == COMPUTE) begin
        // Bypass still spends the four column edges so latency is identical.
        work[{col, 5'b00000} +: 32] <= bypass ? col_cur : col_mix;
        col <= col + 2'd1;
      end
    end
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- AES MixColumns stage that sits directly downstream of the ShiftRows stage and consumes its 128-bit state.
- Column-serial: one 32-bit column is processed per clock, so one 128-bit block completes in 4 compute cycles.
- Valid/ready handshake on both sides.
- A per-block last_round flag bypasses the mixing for the final AES round while keeping latency constant.
- Parameter INVERSE selects InvMixColumns for the decrypt datapath.

Parameters:
- INVERSE, 0, 0 = MixColumns (coefficients 02 03 01 01); 1 = InvMixColumns (coefficients 0e 0b 0d 09).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  data_in and last_round are valid.
- in_ready  output  1  block can accept a new state.
- data_in  input  [0:127]  AES state.
  - Byte k = bits 8k..8k+7, bit 8k is MSB.
  - Column c = bytes 4c..4c+3; row r of column c = byte 4c+r.
- last_round  input  1  sampled with data_in: 1 = pass state unchanged.
- out_valid  output  1  data_out holds a finished block.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  [0:127]  mixed state, same byte ordering as data_in.
- busy  output  1  high in COMPUTE or DONE.

Behaviour:
- Reset (rst_n low at a rising edge, checked before all else):
  - state = IDLE, col counter = 0.
  - in_ready = 1, out_valid = 0, busy = 0, data_out = 0.
  - Internal state register and bypass flag = 0.
  - Reset mid-COMPUTE or mid-DONE discards the block; nothing is emitted.
- States:
  - IDLE
    - in_ready = 1.
    - On in_valid: capture data_in into the work register, capture last_round into the bypass flag, set col = 0, go to COMPUTE.
  - COMPUTE
    - in_ready = 0.
    - Each edge writes column col of the work register through mix_single_column, or copies it unchanged if bypass = 1, then increments col.
    - After the edge that writes col = 3: go to DONE, out_valid = 1.
    - The col counter is 2 bits and wraps to 0.
  - DONE
    - out_valid = 1; data_out = work register, stable until handshake.
    - out_ready = 0: stay in DONE. No timeout; data holds indefinitely.
    - out_ready = 1 and in_valid = 0: go to IDLE, out_valid = 0.
    - out_ready = 1 and in_valid = 1: the output handshake and new capture occur on the same edge; go directly to COMPUTE.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is combinational from out_ready; there is no combinational path from in_valid.
- Latency: out_valid rises 4 edges after the accepting edge, identical for bypass and mix.
- Throughput: back-to-back, one block per 5 cycles with out_ready held high.
- data_out is driven from a register; it must not change while out_valid = 1 and out_ready = 0.
- Column arithmetic, GF(2^8) with modulus 0x11B:
  - Forward, each output byte r: out_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  - Inverse: out_r = e·a_r ^ b·a_(r+1) ^ d·a_(r+2) ^ 9·a_(r+3).
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0), truncated to 8 bits; higher multiples are built by xtime chains.
- in_valid during COMPUTE is ignored; the upstream stage must hold its data until in_ready.

Decomposition:
- Shared package aes_pkg holds:
  - the xtime function and a gf_mul by constant 2/3/9/b/d/e;
  - the constant AES_POLY = 8'h1B;
  - the state enum {IDLE, COMPUTE, DONE}.
- One combinational sub-module, mix_single_column:
  - ports col_in[0:31], col_out[0:31];
  - parameter INVERSE;
  - also reusable by the key-expansion-free round wrapper.

Test Plan:
- INVERSE=0, last_round=0, in: d4bf5d30e0b452aeb84111f11e2798e5 -> out_valid 4 edges after accept, data_out 046681e5e0cb199a48f8d37a2806264c.
- INVERSE=0, single-column vectors:
  - column 0 = db135345 -> 8e4da1bc;
  - columns 1-3 = f20a225c, 01010101, c6c6c6c6 -> 9fdc589d, 01010101, c6c6c6c6.
- INVERSE=1, in: 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5.
- last_round=1, any state, e.g. 00112233445566778899aabbccddeeff -> identical data_out after the same 4-edge latency.
- Backpressure and back-to-back:
  - Hold out_ready = 0 for 10 cycles in DONE: data_out stable, in_ready = 0.
  - Then assert out_ready with in_valid = 1: the same edge completes the output and accepts the next block; second result correct 4 edges later.
- Reset: assert rst_n = 0 during COMPUTE col = 2 -> next edge out_valid = 0, data_out = 0, in_ready = 1, busy = 0; no stale output appears afterwards.
